// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring unsigned divider, one quotient bit per clock,
// with start/ready/valid handshake, remainder output and divide-by-zero flag.
module seq_divider #(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [WD-1:0] i_dividend,
  input  logic [WD-1:0] i_divisor,
  output logic          o_ready,
  output logic          o_valid,
  output logic [WD-1:0] o_quotient,
  output logic [WD-1:0] o_remainder,
  output logic          o_div_zero
);
  localparam int CW = $clog2(WD + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_next;
  logic [WD-1:0] r_a, r_d, r_p;
  logic [CW-1:0] r_cnt;
  logic          r_zero;
  logic [WD:0]   w_sh, w_t;
  logic          w_acc, w_step;
  always_comb begin
    w_acc  = r_state == IDLE && i_start;
    w_step = r_state == RUN && r_cnt != '0;
    w_sh   = {r_p, r_a[WD-1]};
    w_t    = w_sh - {1'b0, r_d};
    w_next = w_acc ? RUN : r_state == RUN ? (w_step ? RUN : DONE) : IDLE;
  end
  // A zero divisor enters RUN with an empty count so it reaches DONE one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a    <= i_dividend;
        r_d    <= i_divisor;
        r_p    <= '0;
        r_zero <= i_divisor == '0;
        r_cnt  <= i_divisor == '0 ? '0 : CW'(WD);
      end else if (w_step) begin
        r_a   <= {r_a[WD-2:0], ~w_t[WD]};
        r_p   <= w_t[WD] ? w_sh[WD-1:0] : w_t[WD-1:0];
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == RUN) begin
        o_quotient  <= r_zero ? '1 : r_a;
        o_remainder <= r_zero ? r_a : r_p;
        o_div_zero  <= r_zero;
      end
    end
  end
  assign o_ready = r_state == IDLE;
  assign o_valid = r_state == DONE;
endmodule
